pdecode_regfile: RTL and testbench
==================================

PDECODE_REGFILE -- requirements
Module: pdecode_regfile

Interface
REQ-001 SHALL provide parameter DATA_W, default 64, meaning register and datapath width in bits.
REQ-002 SHALL provide parameter NREG, default 15, meaning number of architectural registers (index 0..NREG-1).
REQ-003 SHALL provide parameter AW, default 4, meaning register-index width.
REQ-004 SHALL provide parameter RNONE, default 4'hF, meaning the "no register" index.
REQ-005 SHALL have one clock and a synchronous, active-low reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 D_icode, D_ifun  in  4 each  decode-stage instruction code and function.
REQ-009 D_rA, D_rB  in  AW each  decode-stage register specifiers.
REQ-010 D_valC, D_valP  in  DATA_W each  decode-stage constant and next PC.
REQ-011 e_dstE, M_dstE, M_dstM, W_dstE, W_dstM  in  AW each  forwarding and writeback destinations.
REQ-012 e_valE, M_valE, m_valM, W_valE, W_valM  in  DATA_W each  forwarding and writeback values.
REQ-013 E_stall, E_bubble  in  1 each  hold or flush the E pipeline register.
REQ-014 E_icode, E_ifun  out  4 each; E_valA, E_valB, E_valC  out  DATA_W; E_srcA, E_srcB, E_dstE, E_dstM  out  AW  registered E-stage fields.
REQ-015 load_use  out  1  combinational load/use hazard flag (F/D stall request).
REQ-016 dbg_addr  in  AW; dbg_data  out  DATA_W  asynchronous debug read port.

Function
REQ-017 Source and destination selection SHALL be combinational from D_icode:
- srcA = rA for CMOVXX, RMMOVQ, OPQ, PUSHQ; 4 for RET, POPQ; else RNONE.
- srcB = rB for RMMOVQ, MRMOVQ, OPQ; 4 for CALL, RET, PUSHQ, POPQ; else RNONE.
- dstE = rB for CMOVXX, IRMOVQ, OPQ; 4 for CALL, RET, PUSHQ, POPQ; else RNONE.
- dstM = rA for MRMOVQ, POPQ; else RNONE.
REQ-018 d_valA SHALL equal D_valP for JXX/CALL; otherwise the first match in priority order: e_dstE->e_valE, M_dstM->m_valM, M_dstE->M_valE, W_dstM->W_valM, W_dstE->W_valE, else the register file.
REQ-019 d_valB SHALL use the same priority chain as REQ-018, with no valP term.
REQ-020 A source equal to RNONE SHALL never match a forwarding destination and SHALL read as 0.
REQ-021 A register-file read of an index >= NREG SHALL return 0.
REQ-022 The register file SHALL be written on the rising edge: W_valE to W_dstE, and W_valM to W_dstM, skipping any write whose index is RNONE or >= NREG.
REQ-023 If W_dstE == W_dstM, the W_valM write SHALL win.
REQ-024 A read in the same cycle as a write to the same index SHALL return the new value through forwarding (REQ-018), not through the array.
REQ-025 load_use SHALL be 1 when E_icode is MRMOVQ or POPQ, E_dstM != RNONE, and E_dstM equals d_srcA or d_srcB; otherwise 0.
REQ-026 On each rising edge the E register SHALL take exactly one action:
- if E_stall, hold its contents;
- else if E_bubble or load_use, load a bubble;
- else load the decode fields and d_valA, d_valB, D_valC.
REQ-027 E_stall SHALL take priority over E_bubble and load_use.
REQ-028 A bubble SHALL be: icode NOP (4'h1), ifun 0, all values 0, srcA/srcB/dstE/dstM = RNONE.

Reset
REQ-029 When rst_n = 0 at a rising edge, every register-file entry SHALL become 0 and the E register SHALL become a bubble; this takes priority over every other input, including an in-flight writeback or E_stall.
REQ-030 After reset, E_icode SHALL be 4'h1, load_use SHALL be 0, and dbg_data SHALL be 0 for every index.

Verification
REQ-031 Reset, then W_dstE=3, W_valE=0x55 for one cycle -> dbg_addr=3 reads 0x55; dbg_addr=15 reads 0.
REQ-032 OPQ rA=2, rB=3 with e_dstE=2/e_valE=0xA and M_dstE=2/M_valE=0xB -> next E_valA=0xA, E_dstE=3.
REQ-033 E holds MRMOVQ with E_dstM=5 and D holds OPQ rA=5 -> load_use=1; next E_icode=1, E_dstE=RNONE.
REQ-034 W_dstE=W_dstM=6, W_valE=1, W_valM=2 -> R6 = 2.
REQ-035 CALL with D_valP=0x40 and E_stall=1 -> E unchanged for that cycle; after E_stall drops, E_valA=0x40, E_dstE=4.
REQ-036 rst_n=0 asserted while E_stall=1 and a W write is pending -> E becomes a bubble and the target register reads 0.

Source files
------------

// File: rtl/pdecode_regfile.sv
// Y86-style decode stage: source/destination selection, forwarding, register file,
// load/use hazard detection and the E pipeline register.
module pdecode_regfile #(
    parameter int             DATA_W = 64,
    parameter int             NREG   = 15,
    parameter int             AW     = 4,
    parameter logic [AW-1:0]  RNONE  = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [AW-1:0]     D_rA,
    input  logic [AW-1:0]     D_rB,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic [AW-1:0]     e_dstE,
    input  logic [AW-1:0]     M_dstE,
    input  logic [AW-1:0]     M_dstM,
    input  logic [AW-1:0]     W_dstE,
    input  logic [AW-1:0]     W_dstM,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic              E_stall,
    input  logic              E_bubble,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [DATA_W-1:0] E_valC,
    output logic [AW-1:0]     E_srcA,
    output logic [AW-1:0]     E_srcB,
    output logic [AW-1:0]     E_dstE,
    output logic [AW-1:0]     E_dstM,
    output logic              load_use,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [3:0]    I_NOP    = 4'h1;
    localparam logic [3:0]    I_CMOVXX = 4'h2;
    localparam logic [3:0]    I_IRMOVQ = 4'h3;
    localparam logic [3:0]    I_RMMOVQ = 4'h4;
    localparam logic [3:0]    I_MRMOVQ = 4'h5;
    localparam logic [3:0]    I_OPQ    = 4'h6;
    localparam logic [3:0]    I_JXX    = 4'h7;
    localparam logic [3:0]    I_CALL   = 4'h8;
    localparam logic [3:0]    I_RET    = 4'h9;
    localparam logic [3:0]    I_PUSHQ  = 4'hA;
    localparam logic [3:0]    I_POPQ   = 4'hB;
    localparam logic [AW-1:0] R_RSP    = AW'(4);
    localparam logic [AW:0]   NREG_W   = (AW+1)'(NREG);

    logic [DATA_W-1:0] rf_r [NREG];
    logic [AW-1:0]     d_srca_s, d_srcb_s, d_dste_s, d_dstm_s;
    logic [DATA_W-1:0] rf_a_s, rf_b_s, d_vala_s, d_valb_s;
    logic              load_use_s;

    logic [3:0]        ereg_icode_r, ereg_ifun_r;
    logic [DATA_W-1:0] ereg_vala_r, ereg_valb_r, ereg_valc_r;
    logic [AW-1:0]     ereg_srca_r, ereg_srcb_r, ereg_dste_r, ereg_dstm_r;

    // Index names a physical register (RNONE and out-of-range indices do not).
    function automatic logic rf_hit(input logic [AW-1:0] idx);
        return (idx != RNONE) && ({1'b0, idx} < NREG_W);
    endfunction

    // Youngest in-flight producer wins; RNONE never matches and reads as zero.
    function automatic logic [DATA_W-1:0] fwd_val(input logic [AW-1:0] src,
                                                  input logic [DATA_W-1:0] rf_val);
        logic [DATA_W-1:0] v;
        if (src == RNONE)       v = '0;
        else if (src == e_dstE) v = e_valE;
        else if (src == M_dstM) v = m_valM;
        else if (src == M_dstE) v = M_valE;
        else if (src == W_dstM) v = W_valM;
        else if (src == W_dstE) v = W_valE;
        else                    v = rf_val;
        return v;
    endfunction

    // Source/destination register selection from the instruction code.
    always_comb begin
        d_srca_s = RNONE;
        d_srcb_s = RNONE;
        d_dste_s = RNONE;
        d_dstm_s = RNONE;
        case (D_icode)
            I_CMOVXX: begin d_srca_s = D_rA;  d_dste_s = D_rB; end
            I_IRMOVQ: begin d_dste_s = D_rB; end
            I_RMMOVQ: begin d_srca_s = D_rA;  d_srcb_s = D_rB; end
            I_MRMOVQ: begin d_srcb_s = D_rB;  d_dstm_s = D_rA; end
            I_OPQ:    begin d_srca_s = D_rA;  d_srcb_s = D_rB;  d_dste_s = D_rB; end
            I_CALL:   begin d_srcb_s = R_RSP; d_dste_s = R_RSP; end
            I_RET:    begin d_srca_s = R_RSP; d_srcb_s = R_RSP; d_dste_s = R_RSP; end
            I_PUSHQ:  begin d_srca_s = D_rA;  d_srcb_s = R_RSP; d_dste_s = R_RSP; end
            I_POPQ:   begin d_srca_s = R_RSP; d_srcb_s = R_RSP; d_dste_s = R_RSP; d_dstm_s = D_rA; end
            default:  begin d_srca_s = RNONE; end
        endcase
    end

    // Operand values: array read, then forwarding override; jumps/calls carry valP.
    always_comb begin
        rf_a_s = rf_hit(d_srca_s) ? rf_r[d_srca_s] : '0;
        rf_b_s = rf_hit(d_srcb_s) ? rf_r[d_srcb_s] : '0;
        if ((D_icode == I_JXX) || (D_icode == I_CALL)) begin
            d_vala_s = D_valP;
        end else begin
            d_vala_s = fwd_val(d_srca_s, rf_a_s);
        end
        d_valb_s = fwd_val(d_srcb_s, rf_b_s);
    end

    // Load/use hazard: a load in E feeding either source of the instruction in D.
    always_comb begin
        load_use_s = 1'b0;
        if (((ereg_icode_r == I_MRMOVQ) || (ereg_icode_r == I_POPQ)) &&
            (ereg_dstm_r != RNONE) &&
            ((ereg_dstm_r == d_srca_s) || (ereg_dstm_r == d_srcb_s))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Register file write; the M port is written last so it wins on a shared index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_r[i] <= '0;
            end
        end else begin
            if (rf_hit(W_dstE)) begin
                rf_r[W_dstE] <= W_valE;
            end
            if (rf_hit(W_dstM)) begin
                rf_r[W_dstM] <= W_valM;
            end
        end
    end

    // E pipeline register: reset > stall > bubble/hazard > normal load.
    always_ff @(posedge clk) begin
        if (!rst_n || (!E_stall && (E_bubble || load_use_s))) begin
            ereg_icode_r <= I_NOP;
            ereg_ifun_r  <= 4'h0;
            ereg_vala_r  <= '0;
            ereg_valb_r  <= '0;
            ereg_valc_r  <= '0;
            ereg_srca_r  <= RNONE;
            ereg_srcb_r  <= RNONE;
            ereg_dste_r  <= RNONE;
            ereg_dstm_r  <= RNONE;
        end else if (!E_stall) begin
            ereg_icode_r <= D_icode;
            ereg_ifun_r  <= D_ifun;
            ereg_vala_r  <= d_vala_s;
            ereg_valb_r  <= d_valb_s;
            ereg_valc_r  <= D_valC;
            ereg_srca_r  <= d_srca_s;
            ereg_srcb_r  <= d_srcb_s;
            ereg_dste_r  <= d_dste_s;
            ereg_dstm_r  <= d_dstm_s;
        end
    end

    assign E_icode  = ereg_icode_r;
    assign E_ifun   = ereg_ifun_r;
    assign E_valA   = ereg_vala_r;
    assign E_valB   = ereg_valb_r;
    assign E_valC   = ereg_valc_r;
    assign E_srcA   = ereg_srca_r;
    assign E_srcB   = ereg_srcb_r;
    assign E_dstE   = ereg_dste_r;
    assign E_dstM   = ereg_dstm_r;
    assign load_use = load_use_s;
    assign dbg_data = rf_hit(dbg_addr) ? rf_r[dbg_addr] : '0;

endmodule

// File: tb/tb_pdecode_regfile.sv
// Randomized bench for pdecode_regfile against a table-driven reference model,
// preceded by directed scenarios.
module tb_pdecode_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic        E_stall, E_bubble;
    logic [3:0]  E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
    logic [63:0] E_valA, E_valB, E_valC;
    logic        load_use;
    logic [3:0]  dbg_addr;
    logic [63:0] dbg_data;

    int total = 0;
    int bad   = 0;

    logic [63:0] m_rf [16];
    logic [3:0]  me_icode, me_ifun, me_srcA, me_srcB, me_dstE, me_dstM;
    logic [63:0] me_valA, me_valB, me_valC;

    always #5 clk = ~clk;

    pdecode_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM), .W_valE(W_valE), .W_valM(W_valM),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_srcA(E_srcA), .E_srcB(E_srcB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .load_use(load_use), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Role masks: bit k set means icode k uses that field in that way.
    function automatic logic [3:0] sel(input logic [15:0] use_reg, input logic [15:0] use_sp,
                                       input logic [3:0] icode, input logic [3:0] r);
        if (use_reg[icode]) return r;
        if (use_sp[icode])  return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [63:0] fwd(input logic [3:0] src);
        logic [3:0]  d [5];
        logic [63:0] v [5];
        d = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        v = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        if (src == 4'hF) return 64'd0;
        for (int i = 0; i < 5; i++) begin
            if (d[i] == src) return v[i];
        end
        return m_rf[src];
    endfunction

    task automatic model_bubble();
        me_icode = 4'h1; me_ifun = 4'h0;
        me_valA = 64'd0; me_valB = 64'd0; me_valC = 64'd0;
        me_srcA = 4'hF; me_srcB = 4'hF; me_dstE = 4'hF; me_dstM = 4'hF;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 64'd0;
        model_bubble();
    endtask

    task automatic set_idle();
        D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
        D_valC = 64'd0; D_valP = 64'd0;
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = 64'd0; M_valE = 64'd0; m_valM = 64'd0; W_valE = 64'd0; W_valM = 64'd0;
        E_stall = 1'b0; E_bubble = 1'b0; dbg_addr = 4'h0;
    endtask

    function automatic logic [3:0] ridx();
        int r;
        r = $urandom_range(0, 9);
        return (r >= 8) ? 4'hF : 4'(r);
    endfunction

    task automatic rand_inputs();
        rst_n    = ($urandom_range(0, 63) != 0);
        D_icode  = 4'($urandom_range(0, 15));
        D_ifun   = 4'($urandom_range(0, 15));
        D_rA     = ridx(); D_rB = ridx();
        D_valC   = {$urandom, $urandom}; D_valP = {$urandom, $urandom};
        e_dstE   = ridx(); M_dstE = ridx(); M_dstM = ridx(); W_dstE = ridx(); W_dstM = ridx();
        e_valE   = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
        m_valM   = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
        W_valM   = {$urandom, $urandom};
        E_stall  = ($urandom_range(0, 7) == 0);
        E_bubble = ($urandom_range(0, 7) == 0);
        dbg_addr = 4'($urandom_range(0, 15));
    endtask

    // One clock: check combinational outputs, advance the model, check E.
    task automatic cycle();
        logic [3:0]  sa, sb, de, dm;
        logic [63:0] va, vb;
        logic        lu;
        #1;
        sa = sel(16'h0454, 16'h0A00, D_icode, D_rA);
        sb = sel(16'h0070, 16'h0F00, D_icode, D_rB);
        de = sel(16'h004C, 16'h0F00, D_icode, D_rB);
        dm = sel(16'h0820, 16'h0000, D_icode, D_rA);
        va = ((D_icode == 4'h7) || (D_icode == 4'h8)) ? D_valP : fwd(sa);
        vb = fwd(sb);
        lu = ((me_icode == 4'h5) || (me_icode == 4'hB)) && (me_dstM != 4'hF) &&
             ((me_dstM == sa) || (me_dstM == sb));
        check("load_use", 64'(load_use), 64'(lu));
        check("dbg_data", dbg_data, m_rf[dbg_addr]);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (W_dstE != 4'hF) m_rf[W_dstE] = W_valE;
            if (W_dstM != 4'hF) m_rf[W_dstM] = W_valM;
            if (!E_stall) begin
                if (E_bubble || lu) begin
                    model_bubble();
                end else begin
                    me_icode = D_icode; me_ifun = D_ifun;
                    me_valA = va; me_valB = vb; me_valC = D_valC;
                    me_srcA = sa; me_srcB = sb; me_dstE = de; me_dstM = dm;
                end
            end
        end
        #1;
        check("E_icode", 64'(E_icode), 64'(me_icode));
        check("E_ifun",  64'(E_ifun),  64'(me_ifun));
        check("E_valA",  E_valA, me_valA);
        check("E_valB",  E_valB, me_valB);
        check("E_valC",  E_valC, me_valC);
        check("E_srcA",  64'(E_srcA), 64'(me_srcA));
        check("E_srcB",  64'(E_srcB), 64'(me_srcB));
        check("E_dstE",  64'(E_dstE), 64'(me_dstE));
        check("E_dstM",  64'(E_dstM), 64'(me_dstM));
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state
        cycle();
        check("rst_icode", 64'(E_icode), 64'h1);
        check("rst_load_use", 64'(load_use), 64'h0);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            check("rst_dbg", dbg_data, 64'd0);
        end
        rst_n = 1'b1;
        set_idle();

        // Single writeback, then debug reads
        W_dstE = 4'd3; W_valE = 64'h55;
        cycle();
        set_idle();
        dbg_addr = 4'd3;  #1; check("wb_r3", dbg_data, 64'h55);
        dbg_addr = 4'd15; #1; check("wb_r15", dbg_data, 64'h0);

        // Forwarding priority: e stage beats M stage
        set_idle();
        D_icode = 4'h6; D_rA = 4'd2; D_rB = 4'd3;
        e_dstE = 4'd2; e_valE = 64'hA; M_dstE = 4'd2; M_valE = 64'hB;
        cycle();
        check("fwd_valA", E_valA, 64'hA);
        check("fwd_dstE", 64'(E_dstE), 64'h3);

        // Load/use hazard
        set_idle();
        D_icode = 4'h5; D_rA = 4'd5; D_rB = 4'd1;
        cycle();
        set_idle();
        D_icode = 4'h6; D_rA = 4'd5; D_rB = 4'd1;
        #1;
        check("lu_flag", 64'(load_use), 64'h1);
        cycle();
        check("lu_icode", 64'(E_icode), 64'h1);
        check("lu_dstE", 64'(E_dstE), 64'hF);

        // Same-index writeback: M value wins
        set_idle();
        W_dstE = 4'd6; W_dstM = 4'd6; W_valE = 64'd1; W_valM = 64'd2;
        cycle();
        set_idle();
        dbg_addr = 4'd6; #1; check("wb_same_idx", dbg_data, 64'd2);

        // Stall holds E, release loads CALL
        set_idle();
        D_icode = 4'h6; D_rA = 4'd1; D_rB = 4'd2;
        cycle();
        set_idle();
        D_icode = 4'h8; D_valP = 64'h40; E_stall = 1'b1;
        cycle();
        check("stall_icode", 64'(E_icode), 64'h6);
        E_stall = 1'b0;
        cycle();
        check("call_valA", E_valA, 64'h40);
        check("call_dstE", 64'(E_dstE), 64'h4);

        // Reset beats stall and pending writeback
        set_idle();
        W_dstE = 4'd7; W_valE = 64'h77;
        cycle();
        set_idle();
        D_icode = 4'h3; D_rB = 4'd2;
        cycle();
        set_idle();
        W_dstE = 4'd7; W_valE = 64'h99; E_stall = 1'b1; rst_n = 1'b0;
        cycle();
        check("rst_pri_icode", 64'(E_icode), 64'h1);
        rst_n = 1'b1;
        set_idle();
        dbg_addr = 4'd7; #1; check("rst_pri_r7", dbg_data, 64'd0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            rand_inputs();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
